// File: rtl/difftest_pkg.sv
// Shared difftest definitions: hypervisor-CSR ordering and the delta record handed to the bridge.
package difftest_pkg;
  localparam int DIFF_HCSR_NUM = 17;
  localparam int DIFF_HCSR_W   = 64;

  localparam int HCSR_VIRTMODE   = 0;
  localparam int HCSR_MTVAL2     = 1;
  localparam int HCSR_MTINST     = 2;
  localparam int HCSR_HSTATUS    = 3;
  localparam int HCSR_HEDELEG    = 4;
  localparam int HCSR_HIDELEG    = 5;
  localparam int HCSR_HCOUNTEREN = 6;
  localparam int HCSR_HTVAL      = 7;
  localparam int HCSR_HTINST     = 8;
  localparam int HCSR_HGATP      = 9;
  localparam int HCSR_VSSTATUS   = 10;
  localparam int HCSR_VSTVEC     = 11;
  localparam int HCSR_VSEPC      = 12;
  localparam int HCSR_VSCAUSE    = 13;
  localparam int HCSR_VSTVAL     = 14;
  localparam int HCSR_VSATP      = 15;
  localparam int HCSR_VSSCRATCH  = 16;

  typedef struct packed {
    logic [DIFF_HCSR_NUM*DIFF_HCSR_W-1:0] csr;
    logic [DIFF_HCSR_NUM-1:0]             mask;
    logic [31:0]                          stamp;
    logic [7:0]                           coreid;
  } hcsr_delta_t;
endpackage

// File: rtl/difftest_sync_fifo.sv
// Pointer-based queue with registered storage; a push into a full queue is legal when a pop
// happens on the same edge. When empty, the head port keeps showing the most recently popped slot.
module difftest_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    show_idx;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // The slot just behind the read pointer can't be rewritten while empty, so it still holds the last head.
  assign show_idx = empty ? (rd_ptr[AW-1:0] - AW'(1)) : rd_ptr[AW-1:0];
  assign head_dat = mem[show_idx];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/difftest_hcsr_delta_queue.sv
// Snapshots hypervisor CSRs on enabled cycles and queues only snapshots that differ from the last
// one emitted, tagged with a change mask and cycle stamp. Overflow drops are coalesced and counted.
module difftest_hcsr_delta_queue
  import difftest_pkg::*;
#(
  parameter int                   NUM_CSR = DIFF_HCSR_NUM,
  parameter int                   DATA_W  = DIFF_HCSR_W,
  parameter int                   DEPTH   = 4,
  parameter int                   STAMP_W = 32,
  parameter logic [NUM_CSR-1:0]   CSR_IGN = '0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      io_enable,
  input  logic                      io_force,
  input  logic [NUM_CSR*DATA_W-1:0] io_csr,
  input  logic [7:0]                io_coreid,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_CSR*DATA_W-1:0] out_csr,
  output logic [NUM_CSR-1:0]        out_mask,
  output logic [STAMP_W-1:0]        out_stamp,
  output logic [7:0]                out_coreid,
  output logic [15:0]               out_drop_cnt
);
  typedef struct packed {
    logic [NUM_CSR*DATA_W-1:0] csr;
    logic [NUM_CSR-1:0]        mask;
    logic [STAMP_W-1:0]        stamp;
    logic [7:0]                coreid;
  } delta_t;

  delta_t                    push_entry;
  delta_t                    head_entry;
  logic                      empty;
  logic                      full;
  logic [NUM_CSR*DATA_W-1:0] shadow_q;
  logic                      first_pend_q;
  logic [STAMP_W-1:0]        stamp_q;
  logic [15:0]               drop_cnt_q;
  logic [NUM_CSR-1:0]        diff_mask;
  logic                      want_push;
  logic                      can_push;
  logic                      do_push;
  logic                      do_pop;

  always_comb begin
    diff_mask = '0;
    for (int i = 0; i < NUM_CSR; i++) begin
      diff_mask[i] = (io_csr[i*DATA_W +: DATA_W] != shadow_q[i*DATA_W +: DATA_W]) & ~CSR_IGN[i];
    end
  end

  assign out_valid = !empty;
  assign do_pop    = out_valid & out_ready;
  assign want_push = io_enable & ((|diff_mask) | io_force | first_pend_q);
  assign can_push  = !full | do_pop;
  assign do_push   = want_push & can_push;

  // First and forced snapshots are full resyncs, so every CSR is flagged, ignored ones included.
  always_comb begin
    push_entry        = '0;
    push_entry.csr    = io_csr;
    push_entry.mask   = (first_pend_q | io_force) ? {NUM_CSR{1'b1}} : diff_mask;
    push_entry.stamp  = stamp_q;
    push_entry.coreid = io_coreid;
  end

  difftest_sync_fifo #(
    .WIDTH ($bits(delta_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (do_push),
    .push_dat (push_entry),
    .pop      (do_pop),
    .head_dat (head_entry),
    .empty    (empty),
    .full     (full)
  );

  assign out_csr      = head_entry.csr;
  assign out_mask     = head_entry.mask;
  assign out_stamp    = head_entry.stamp;
  assign out_coreid   = head_entry.coreid;
  assign out_drop_cnt = drop_cnt_q;

  // A drop leaves the shadow alone so the change is re-detected on the next enabled cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shadow_q     <= '0;
      first_pend_q <= 1'b1;
      stamp_q      <= '0;
      drop_cnt_q   <= '0;
    end else begin
      stamp_q <= stamp_q + STAMP_W'(1);
      if (do_push) begin
        shadow_q     <= io_csr;
        first_pend_q <= 1'b0;
      end else if (want_push && drop_cnt_q != 16'hFFFF) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_difftest_hcsr_delta_queue.sv
// Directed and random stimulus against a queue-based reference model of the delta queue.
module tb_difftest_hcsr_delta_queue;
  localparam int            N   = 17;
  localparam int            DW  = 64;
  localparam int            CW  = N*DW;
  localparam int            DEP = 4;
  localparam logic [N-1:0]  IGN = 17'h00001;

  typedef struct packed {
    logic [CW-1:0] csr;
    logic [N-1:0]  mask;
    logic [31:0]   stamp;
    logic [7:0]    coreid;
  } ent_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          io_enable, io_force, out_ready;
  logic [CW-1:0] io_csr;
  logic [7:0]    io_coreid;
  logic          out_valid;
  logic [CW-1:0] out_csr;
  logic [N-1:0]  out_mask;
  logic [31:0]   out_stamp;
  logic [7:0]    out_coreid;
  logic [15:0]   out_drop_cnt;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  ent_t          m_q[$];
  ent_t          m_last;
  logic [CW-1:0] m_shadow;
  bit            m_first;
  int            m_drop;
  logic [31:0]   m_stamp;

  difftest_hcsr_delta_queue #(
    .NUM_CSR (N), .DATA_W (DW), .DEPTH (DEP), .STAMP_W (32), .CSR_IGN (IGN)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .io_enable    (io_enable),
    .io_force     (io_force),
    .io_csr       (io_csr),
    .io_coreid    (io_coreid),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_csr      (out_csr),
    .out_mask     (out_mask),
    .out_stamp    (out_stamp),
    .out_coreid   (out_coreid),
    .out_drop_cnt (out_drop_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_last   = '0;
    m_shadow = '0;
    m_first  = 1'b1;
    m_drop   = 0;
    m_stamp  = '0;
  endtask

  task automatic compare();
    ent_t h;
    h = (m_q.size() > 0) ? m_q[0] : m_last;
    check("valid",  {{(CW-1){1'b0}}, out_valid}, {{(CW-1){1'b0}}, (m_q.size() > 0)});
    check("csr",    out_csr, h.csr);
    check("mask",   CW'(out_mask), CW'(h.mask));
    check("stamp",  CW'(out_stamp), CW'(h.stamp));
    check("coreid", CW'(out_coreid), CW'(h.coreid));
    check("drop",   CW'(out_drop_cnt), CW'(m_drop));
  endtask

  // One clock: decide the cycle's outcome from the rules, let the edge happen, then compare.
  task automatic step();
    logic [N-1:0] m;
    bit pop, want, can;
    ent_t e;
    pop = (m_q.size() > 0) && out_ready;
    m = '0;
    for (int i = 0; i < N; i++)
      if (io_csr[i*DW +: DW] != m_shadow[i*DW +: DW] && !IGN[i]) m[i] = 1'b1;
    want = io_enable && (m != 0 || io_force || m_first);
    can  = (m_q.size() < DEP) || pop;
    e.csr    = io_csr;
    e.mask   = (io_force || m_first) ? {N{1'b1}} : m;
    e.stamp  = m_stamp;
    e.coreid = io_coreid;
    @(posedge clock);
    if (pop) m_last = m_q.pop_front();
    if (want && can) begin
      m_q.push_back(e);
      m_shadow = io_csr;
      m_first  = 1'b0;
    end else if (want && m_drop < 65535) begin
      m_drop++;
    end
    m_stamp = m_stamp + 32'd1;
    #1;
    compare();
  endtask

  task automatic set_csr(input int idx, input logic [63:0] v);
    io_csr[idx*DW +: DW] = v;
  endtask

  initial begin
    int n;
    reset = 1'b0; io_enable = 0; io_force = 0; out_ready = 0; io_csr = '0; io_coreid = 8'h3;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    compare();
    reset = 1'b1;

    // first enabled cycle after reset: full-mask snapshot; unchanged next cycle: nothing new
    io_enable = 1;
    step();
    check("t1_mask", CW'(out_mask), CW'(17'h1FFFF));
    check("t1_stamp", CW'(out_stamp), CW'(0));
    step();
    io_enable = 0; out_ready = 1;
    step();
    check("t1_empty", CW'(out_valid), CW'(0));

    // single hstatus change
    io_enable = 1;
    set_csr(3, 64'h2_0000_0000);
    step();
    check("t2_valid", CW'(out_valid), CW'(1));
    check("t2_mask", CW'(out_mask), CW'(17'h00008));
    check("t2_hstatus", CW'(out_csr[3*DW +: DW]), CW'(64'h2_0000_0000));
    io_enable = 0;
    step();

    // overflow: five changes with the bridge stalled, then drain
    out_ready = 0; io_enable = 1;
    for (int k = 0; k < 5; k++) begin
      set_csr(4, 64'(k + 1));
      step();
    end
    check("t3_drop", CW'(out_drop_cnt), CW'(1));
    out_ready = 1;
    n = 0;
    while (out_valid && n < 12) begin
      step();
      n++;
    end
    check("t3_drain", CW'(out_valid), CW'(0));
    check("t3_last_hedeleg", CW'(out_csr[4*DW +: DW]), CW'(5));

    // full queue, pop and push on the same edge
    out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      set_csr(5, 64'(16 + k));
      step();
    end
    out_ready = 1;
    set_csr(5, 64'h99);
    step();
    check("t4_drop", CW'(out_drop_cnt), CW'(1));
    io_enable = 0;
    n = 0;
    while (out_valid && n < 12) begin
      step();
      n++;
    end
    check("t4_count", CW'(n), CW'(4));

    // ignored CSR never triggers; force pushes all ones
    io_enable = 1;
    set_csr(0, 64'h1);
    step();
    check("t5_ign", CW'(out_valid), CW'(0));
    io_force = 1;
    step();
    check("t5_force_mask", CW'(out_mask), CW'(17'h1FFFF));
    io_force = 0; io_enable = 0;
    step();

    // asynchronous reset with entries queued
    out_ready = 0; io_enable = 1;
    for (int k = 0; k < 3; k++) begin
      set_csr(6, 64'(40 + k));
      step();
    end
    #1;
    reset = 1'b0;
    #1;
    check("t6_valid", CW'(out_valid), CW'(0));
    check("t6_drop", CW'(out_drop_cnt), CW'(0));
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    step();
    check("t6_mask", CW'(out_mask), CW'(17'h1FFFF));

    // random traffic
    for (int t = 0; t < 400; t++) begin
      io_enable = ($urandom_range(3) != 0);
      io_force  = ($urandom_range(15) == 0);
      out_ready = ($urandom_range(2) != 0);
      io_coreid = 8'($urandom);
      if ($urandom_range(1) == 1) set_csr($urandom_range(N - 1), 64'($urandom_range(3)));
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
